// File: rtl/design1_io_stage_if.sv
// Handshake and core-drive bundle for design1_io_stage: upstream vector port,
// combinational-core drive/return, and downstream result port.
interface design1_io_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] in_data;
  logic [13:0] core_in;
  logic [7:0]  core_out;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [3:0]  out_tag;
  logic        busy;

  modport slave (
    input  in_valid, in_data, core_out, out_ready,
    output in_ready, core_in, out_valid, out_data, out_tag, busy
  );

  modport master (
    output in_valid, in_data, core_out, out_ready,
    input  in_ready, core_in, out_valid, out_data, out_tag, busy
  );
endinterface

// File: rtl/design1_io_stage.sv
// Launches a 14-bit vector into a combinational core, waits SETTLE_CYCLES,
// captures the 8-bit result with a sequence tag into a 2-entry result FIFO.
module design1_io_stage #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  design1_io_stage_if.slave  bus
);

  localparam logic [3:0] SETTLE_LD = SETTLE_CYCLES[3:0];

  typedef enum logic {IDLE = 1'b0, SETTLE = 1'b1} state_t;

  typedef struct packed {
    logic [3:0] tag;
    logic [7:0] data;
  } res_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [3:0]  r_seq;
  logic [3:0]  r_tag;
  logic [13:0] r_core_in;
  res_t        r_fifo [2];
  logic [1:0]  r_occ;

  logic w_in_ready, w_accept, w_push, w_pop;
  res_t w_new;

  // rst_n gates in_ready so nothing is offered acceptance while held in reset
  assign w_in_ready = rst_n && (r_state == IDLE) && (r_occ < 2'd2);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_push     = (r_state == SETTLE) && (r_cnt == 4'd0);
  assign w_pop      = (r_occ != 2'd0) && bus.out_ready;
  assign w_new      = '{tag: r_tag, data: bus.core_out};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: if (w_accept) begin
        w_state_nxt = SETTLE;
        w_cnt_nxt   = SETTLE_LD;
      end
      SETTLE: if (r_cnt == 4'd0) w_state_nxt = IDLE;
              else               w_cnt_nxt   = r_cnt - 4'd1;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_core_in <= '0;
      r_seq     <= '0;
      r_tag     <= '0;
    end else if (w_accept) begin
      r_core_in <= bus.in_data;
      r_tag     <= r_seq;
      r_seq     <= r_seq + 4'd1;
    end
  end

  // Head lives in slot 0; slot 1 only holds data when occupancy is 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_occ     <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_fifo[0] <= w_new;
          else               r_fifo[1] <= w_new;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_fifo[0] <= r_fifo[1];
          r_occ     <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) r_fifo[0] <= w_new;
          else begin
            r_fifo[0] <= r_fifo[1];
            r_fifo[1] <= w_new;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.core_in   = r_core_in;
  assign bus.out_valid = (r_occ != 2'd0);
  assign bus.out_data  = r_fifo[0].data;
  assign bus.out_tag   = r_fifo[0].tag;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_design1_io_stage.sv
// Bench for design1_io_stage: two instances (settle 2 and settle 0) share one
// stimulus stream and are checked each cycle against a timestamp/queue model.
module tb_design1_io_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [13:0] in_data;
  logic        out_ready;

  always #5 clk = ~clk;

  design1_io_stage_if if0 ();
  design1_io_stage_if if1 ();

  function automatic logic [7:0] core_f(input logic [13:0] x);
    return (x[7:0] + {2'b00, x[13:8]}) ^ 8'h3C;
  endfunction

  assign if0.in_valid  = in_valid;
  assign if0.in_data   = in_data;
  assign if0.out_ready = out_ready;
  assign if0.core_out  = core_f(if0.core_in);
  assign if1.in_valid  = in_valid;
  assign if1.in_data   = in_data;
  assign if1.out_ready = out_ready;
  assign if1.core_out  = core_f(if1.core_in);

  design1_io_stage #(.SETTLE_CYCLES(2)) u_s2 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  design1_io_stage #(.SETTLE_CYCLES(0)) u_s0 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  logic [1:0]  o_rdy, o_busy, o_vld;
  logic [13:0] o_cin [2];
  logic [7:0]  o_dat [2];
  logic [3:0]  o_tag [2];
  assign o_rdy[0] = if0.in_ready;   assign o_rdy[1] = if1.in_ready;
  assign o_busy[0] = if0.busy;      assign o_busy[1] = if1.busy;
  assign o_vld[0] = if0.out_valid;  assign o_vld[1] = if1.out_valid;
  assign o_cin[0] = if0.core_in;    assign o_cin[1] = if1.core_in;
  assign o_dat[0] = if0.out_data;   assign o_dat[1] = if1.out_data;
  assign o_tag[0] = if0.out_tag;    assign o_tag[1] = if1.out_tag;

  // Model: each launch records the edge number at which its result lands;
  // results go into an unbounded ring read from m_rd, written at m_wr.
  int          m_cap [2];
  logic [13:0] m_vec [2];
  int          m_seq [2];
  logic [7:0]  mq_d  [2][16];
  logic [3:0]  mq_t  [2][16];
  int          m_rd  [2];
  int          m_wr  [2];
  int          edge_no;

  int n_vec  = 0;
  int n_err  = 0;
  int n_pop, n_acc;

  function automatic int sc(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic int m_cnt(input int k);
    return m_wr[k] - m_rd[k];
  endfunction

  function automatic bit m_rdy(input int k);
    return rst_n && (m_cap[k] < 0) && (m_cnt(k) < 2);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_cap[k] = -1; m_vec[k] = '0; m_seq[k] = 0; m_rd[k] = 0; m_wr[k] = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("in_ready%0d", k), 32'(o_rdy[k]), 32'(m_rdy(k)));
      chk($sformatf("busy%0d", k), 32'(o_busy[k]), 32'(m_cap[k] >= 0));
      chk($sformatf("out_valid%0d", k), 32'(o_vld[k]), 32'(m_cnt(k) > 0));
      chk($sformatf("core_in%0d", k), 32'(o_cin[k]), 32'(m_vec[k]));
      if (m_cnt(k) > 0) begin
        chk($sformatf("out_data%0d", k), 32'(o_dat[k]), 32'(mq_d[k][m_rd[k] % 16]));
        chk($sformatf("out_tag%0d", k), 32'(o_tag[k]), 32'(mq_t[k][m_rd[k] % 16]));
      end
      if (!rst_n) begin
        chk($sformatf("rst_out_data%0d", k), 32'(o_dat[k]), 32'h0);
        chk($sformatf("rst_out_tag%0d", k), 32'(o_tag[k]), 32'h0);
      end
    end
  endtask

  // One clock: decide handshakes from the model, take the edge, update, compare.
  task automatic step();
    bit          acc [2];
    bit          pop [2];
    logic [13:0] d;
    for (int k = 0; k < 2; k++) begin
      acc[k] = in_valid && m_rdy(k);
      pop[k] = out_ready && (m_cnt(k) > 0);
    end
    d = in_data;
    @(posedge clk);
    n_vec++;
    if (!rst_n) m_reset();
    else begin
      for (int k = 0; k < 2; k++) begin
        if (pop[k]) m_rd[k]++;
        if (m_cap[k] == edge_no) begin
          mq_d[k][m_wr[k] % 16] = core_f(m_vec[k]);
          mq_t[k][m_wr[k] % 16] = 4'(m_seq[k] - 1);
          m_wr[k]++;
          m_cap[k] = -1;
        end
        if (acc[k]) begin
          m_vec[k] = d;
          m_cap[k] = edge_no + sc(k) + 1;
          m_seq[k]++;
        end
      end
    end
    edge_no++;
    #1 cmp_all();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    edge_no = 0;
    m_reset();
    repeat (3) step();

    // Single vector after reset, then FIFO fills with out_ready low
    rst_n = 1'b1; in_valid = 1'b1; in_data = 14'h0001;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) begin
        chk("first_core_in", 32'(o_cin[0]), 32'h0001);
        chk("first_busy_s2", 32'(o_busy[0]), 32'h1);
        chk("first_busy_s0", 32'(o_busy[1]), 32'h1);
      end
      if (i == 1) begin
        chk("s0_busy_one_cycle", 32'(o_busy[1]), 32'h0);
        chk("s0_cap_valid", 32'(o_vld[1]), 32'h1);
        chk("s0_cap_data", 32'(o_dat[1]), 32'h3D);
      end
      if (i == 2) chk("s2_not_yet_valid", 32'(o_vld[0]), 32'h0);
      if (i == 3) begin
        chk("s2_cap_valid", 32'(o_vld[0]), 32'h1);
        chk("s2_cap_data", 32'(o_dat[0]), 32'h3D);
        chk("s2_cap_tag", 32'(o_tag[0]), 32'h0);
      end
      if (i == 7) begin
        chk("full_in_ready", 32'(o_rdy[0]), 32'h0);
        chk("full_head_tag", 32'(o_tag[0]), 32'h0);
      end
    end
    out_ready = 1'b1; step();
    chk("after_pop_tag", 32'(o_tag[0]), 32'h1);
    chk("after_pop_ready", 32'(o_rdy[0]), 32'h1);
    out_ready = 1'b0;
    repeat (4) step();
    out_ready = 1'b1; step();
    chk("third_tag", 32'(o_tag[0]), 32'h2);

    // Stream 17 vectors with out_ready high; tags must wrap 15 -> 0
    rst_n = 1'b0; step();
    rst_n = 1'b1; out_ready = 1'b1; n_pop = 0; n_acc = 0;
    for (int c = 0; c < 200 && n_pop < 17; c++) begin
      if (o_vld[0] && out_ready) begin
        chk("stream_tag", 32'(o_tag[0]), 32'(n_pop % 16));
        n_pop++;
      end
      in_data  = 14'($urandom);
      in_valid = (n_acc < 17);
      if (in_valid && m_rdy(0)) n_acc++;
      step();
    end
    chk("stream_count", 32'(n_pop), 32'd17);

    // Asynchronous reset while the settle counter sits at 1
    in_valid = 1'b1; out_ready = 1'b0; in_data = 14'h2AAA; step();
    chk("abort_busy_before", 32'(o_busy[0]), 32'h1);
    in_valid = 1'b0; step();
    #2 rst_n = 1'b0;
    #1 m_reset(); cmp_all();
    chk("abort_busy", 32'(o_busy[0]), 32'h0);
    chk("abort_core_in", 32'(o_cin[0]), 32'h0);
    chk("abort_valid", 32'(o_vld[1]), 32'h0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("abort_no_result", 32'(o_vld[0]), 32'h0);
    end

    // Random traffic with occasional reset pulses
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 14'($urandom);
      out_ready = ($urandom_range(0, 1) != 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
